// File: rtl/gcd_method_responder_if.sv
// -----------------------------------------------------------------------------
// gcd_method_responder_if
// Call/return bundle between a caller and the GCD responder.
//   gcd_a, gcd_b : unsigned operands, sampled by the responder on the start edge
//   gcd_req      : call request level, a call starts on its rising edge
//   gcd_busy     : high while a call is in progress
//   gcd_return   : result of the last completed call
//   gcd_err      : watchdog abort flag (always 0 unless the watchdog is built in)
// Modports: master = caller side, slave = responder side.
// -----------------------------------------------------------------------------
interface gcd_method_responder_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_req;
  logic             gcd_busy;
  logic [WIDTH-1:0] gcd_return;
  logic             gcd_err;

  modport master (
    output gcd_a,
    output gcd_b,
    output gcd_req,
    input  gcd_busy,
    input  gcd_return,
    input  gcd_err
  );

  modport slave (
    input  gcd_a,
    input  gcd_b,
    input  gcd_req,
    output gcd_busy,
    output gcd_return,
    output gcd_err
  );
endinterface

// File: rtl/gcd_method_responder.sv
// -----------------------------------------------------------------------------
// gcd_method_responder
// Computes gcd(a, b) of two unsigned WIDTH-bit operands with the binary
// (Stein) algorithm, one step per clock, behind a level-request/busy
// call interface.
//
// Ports:
//   clk   : single clock, all state updates on its rising edge
//   reset : asynchronous, active-high reset
//   bus   : gcd_method_responder_if.slave (gcd_a, gcd_b, gcd_req in;
//           gcd_busy, gcd_return, gcd_err out)
//
// Optional feature: define GCD_WATCHDOG_EN to add a step counter that aborts
// a call after 4*WIDTH SHIFT/REDUCE steps, returning 0 with gcd_err set.
// Without the macro the counter is absent and gcd_err is tied low.
// -----------------------------------------------------------------------------
module gcd_method_responder #(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  gcd_method_responder_if.slave bus
);

  // k counts common factors of two; it never exceeds WIDTH-1.
  localparam int K_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_REDUCE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_r;
  logic             req_d_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [K_W-1:0]   k_r;
  logic [WIDTH-1:0] result_r;
  logic             busy_r;
  logic [WIDTH-1:0] return_r;
  logic             wd_hit_s;

`ifdef GCD_WATCHDOG_EN
  localparam int             WD_W     = $clog2(4 * WIDTH) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(4 * WIDTH);

  logic [WD_W-1:0] wd_cnt_r;
  logic            err_r;

  // Abort once the step budget is used up.
  assign wd_hit_s    = (wd_cnt_r == WD_LIMIT);
  assign bus.gcd_err = err_r;
`else
  assign wd_hit_s    = 1'b0;
  assign bus.gcd_err = 1'b0;
`endif

  assign bus.gcd_busy   = busy_r;
  assign bus.gcd_return = return_r;

  // Call FSM: start detection, binary GCD datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      req_d_r  <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      k_r      <= {K_W{1'b0}};
      result_r <= {WIDTH{1'b0}};
      busy_r   <= 1'b0;
      return_r <= {WIDTH{1'b0}};
`ifdef GCD_WATCHDOG_EN
      wd_cnt_r <= {WD_W{1'b0}};
      err_r    <= 1'b0;
`endif
    end else begin
      req_d_r <= bus.gcd_req;
      case (state_r)
        ST_IDLE: begin
          // Only a fresh rising edge starts a call; edges seen while busy are dropped.
          if (bus.gcd_req && !req_d_r) begin
            a_r     <= bus.gcd_a;
            b_r     <= bus.gcd_b;
            busy_r  <= 1'b1;
            state_r <= ST_INIT;
`ifdef GCD_WATCHDOG_EN
            err_r   <= 1'b0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_INIT: begin
`ifdef GCD_WATCHDOG_EN
          wd_cnt_r <= {WD_W{1'b0}};
`endif
          // A zero operand short-circuits: gcd(0, x) = x, gcd(0, 0) = 0.
          if (a_r == {WIDTH{1'b0}}) begin
            result_r <= b_r;
            state_r  <= ST_DONE;
          end else if (b_r == {WIDTH{1'b0}}) begin
            result_r <= a_r;
            state_r  <= ST_DONE;
          end else begin
            k_r     <= {K_W{1'b0}};
            state_r <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (wd_hit_s) begin
            result_r <= {WIDTH{1'b0}};
            state_r  <= ST_DONE;
`ifdef GCD_WATCHDOG_EN
            err_r    <= 1'b1;
`endif
          end else begin
`ifdef GCD_WATCHDOG_EN
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
`endif
            // Strip common powers of two, remembered in k.
            if (!a_r[0] && !b_r[0]) begin
              a_r <= a_r >> 1;
              b_r <= b_r >> 1;
              k_r <= k_r + K_W'(1);
            end else begin
              state_r <= ST_REDUCE;
            end
          end
        end

        ST_REDUCE: begin
          if (wd_hit_s) begin
            result_r <= {WIDTH{1'b0}};
            state_r  <= ST_DONE;
`ifdef GCD_WATCHDOG_EN
            err_r    <= 1'b1;
`endif
          end else begin
`ifdef GCD_WATCHDOG_EN
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
`endif
            // Difference of two odd values is even, so it is halved right away.
            if (a_r == b_r) begin
              result_r <= a_r << k_r;
              state_r  <= ST_DONE;
            end else if (!a_r[0]) begin
              a_r <= a_r >> 1;
            end else if (!b_r[0]) begin
              b_r <= b_r >> 1;
            end else if (a_r > b_r) begin
              a_r <= (a_r - b_r) >> 1;
            end else begin
              b_r <= (b_r - a_r) >> 1;
            end
          end
        end

        ST_DONE: begin
          return_r <= result_r;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end

        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_method_responder.sv
// -----------------------------------------------------------------------------
// tb_gcd_method_responder
// Directed, table-driven bench for gcd_method_responder (WIDTH = 32), plus
// hand-written sequences for held request, mid-call changes and mid-call reset.
// -----------------------------------------------------------------------------
module tb_gcd_method_responder;

  localparam int W       = 32;
  localparam int MAX_LAT = 3 * W + 3;
  localparam int ZER_LAT = 3;
  localparam int N_VEC   = 12;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           max_lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gcd_method_responder_if #(.WIDTH(W)) bus ();

  gcd_method_responder #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    n_vec++;
    if (act > lim) begin
      n_bad++;
      $display("FAIL %s latency: got %0d cycles, expected <= %0d", name, act, lim);
    end
  endtask

  // Called on the negedge after the start edge; returns edges from start to busy low.
  task automatic wait_idle(input string name, output int cycles);
    cycles = 1;
    while (bus.gcd_busy === 1'b1 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    if (bus.gcd_busy !== 1'b0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s timeout: busy=%b after %0d cycles, expected 0", name, bus.gcd_busy, cycles);
    end
  endtask

  task automatic run_call(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, input int max_lat);
    int cycles;
    bus.gcd_a   = a;
    bus.gcd_b   = b;
    bus.gcd_req = 1'b1;
    @(negedge clk);
    bus.gcd_req = 1'b0;
    check({name, " busy_rise"}, W'(bus.gcd_busy), W'(1));
    wait_idle(name, cycles);
    check_le(name, cycles, max_lat);
    check({name, " return"}, bus.gcd_return, exp);
    check({name, " err"}, W'(bus.gcd_err), {W{1'b0}});
    @(negedge clk);
  endtask

  vec_t vecs [N_VEC];

  initial begin
    int cycles;
    int seen;

    vecs[0]  = '{32'd48,         32'd18,         32'd6,          MAX_LAT};
    vecs[1]  = '{32'd0,          32'd7,          32'd7,          ZER_LAT};
    vecs[2]  = '{32'd0,          32'd0,          32'd0,          ZER_LAT};
    vecs[3]  = '{32'd7,          32'd0,          32'd7,          ZER_LAT};
    vecs[4]  = '{32'h8000_0000,  32'h0010_0000,  32'h0010_0000,  MAX_LAT};
    vecs[5]  = '{32'hFFFF_FFFF,  32'd1,          32'd1,          MAX_LAT};
    vecs[6]  = '{32'd1071,       32'd462,        32'd21,         MAX_LAT};
    vecs[7]  = '{32'd17,         32'd5,          32'd1,          MAX_LAT};
    vecs[8]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  MAX_LAT};
    vecs[9]  = '{32'd21,         32'd14,         32'd7,          MAX_LAT};
    vecs[10] = '{32'd5,          32'd35,         32'd5,          MAX_LAT};
    vecs[11] = '{32'd100,        32'd75,         32'd25,         MAX_LAT};

    reset       = 1'b1;
    bus.gcd_a   = {W{1'b0}};
    bus.gcd_b   = {W{1'b0}};
    bus.gcd_req = 1'b0;

    @(negedge clk);
    check("reset busy",   W'(bus.gcd_busy), {W{1'b0}});
    check("reset return", bus.gcd_return,   {W{1'b0}});
    check("reset err",    W'(bus.gcd_err),  {W{1'b0}});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < N_VEC; i++) begin
      run_call($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].max_lat);
    end

    // Held request: exactly one call, no restart while req stays high.
    bus.gcd_a   = 32'd12;
    bus.gcd_b   = 32'd8;
    bus.gcd_req = 1'b1;
    @(negedge clk);
    check("hold busy_rise", W'(bus.gcd_busy), W'(1));
    wait_idle("hold", cycles);
    check("hold return", bus.gcd_return, 32'd4);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gcd_busy !== 1'b0) seen++;
    end
    check("hold no restart", W'(seen), {W{1'b0}});
    bus.gcd_req = 1'b0;
    @(negedge clk);

    // Operand change and re-pulsed request while busy are both ignored.
    bus.gcd_a   = 32'd1071;
    bus.gcd_b   = 32'd462;
    bus.gcd_req = 1'b1;
    @(negedge clk);
    bus.gcd_req = 1'b0;
    check("midchg busy_rise", W'(bus.gcd_busy), W'(1));
    repeat (2) @(negedge clk);
    bus.gcd_a   = 32'd9;
    bus.gcd_b   = 32'd6;
    bus.gcd_req = 1'b1;
    @(negedge clk);
    bus.gcd_req = 1'b0;
    wait_idle("midchg", cycles);
    check("midchg return", bus.gcd_return, 32'd21);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.gcd_busy !== 1'b0) seen++;
    end
    check("midchg no queued call", W'(seen), {W{1'b0}});
    check("midchg return held", bus.gcd_return, 32'd21);

    // Reset mid-call aborts at once; a req held through reset starts on release.
    bus.gcd_a   = 32'hFFFF_FFFF;
    bus.gcd_b   = 32'd1;
    bus.gcd_req = 1'b1;
    @(negedge clk);
    bus.gcd_req = 1'b0;
    repeat (5) @(negedge clk);
    check("abort busy before reset", W'(bus.gcd_busy), W'(1));
    reset = 1'b1;
    #1;
    check("abort busy",   W'(bus.gcd_busy), {W{1'b0}});
    check("abort return", bus.gcd_return,   {W{1'b0}});
    check("abort err",    W'(bus.gcd_err),  {W{1'b0}});
    bus.gcd_a   = 32'd21;
    bus.gcd_b   = 32'd14;
    bus.gcd_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset busy_rise", W'(bus.gcd_busy), W'(1));
    bus.gcd_req = 1'b0;
    wait_idle("post-reset", cycles);
    check_le("post-reset", cycles, MAX_LAT);
    check("post-reset return", bus.gcd_return, 32'd7);
    check("post-reset err",    W'(bus.gcd_err), {W{1'b0}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gcd_method_responder.md
GCD_METHOD_RESPONDER -- requirements
Module: gcd_method_responder

Interface
REQ-001 The parameter WIDTH, default 32, SHALL set the operand and result width in bits.
REQ-002 The port clk, input, 1 bit, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 The port reset, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 The port gcd_a, input, WIDTH bits, SHALL be the first unsigned argument.
REQ-005 The port gcd_b, input, WIDTH bits, SHALL be the second unsigned argument.
REQ-006 The port gcd_req, input, 1 bit, SHALL be the call request, a level driven by the caller.
REQ-007 The port gcd_busy, output, 1 bit, SHALL be high while a call is in progress.
REQ-008 The port gcd_return, output, WIDTH bits, SHALL be the result of the last completed call.
REQ-009 The port gcd_err, output, 1 bit, SHALL flag a watchdog abort (see Configuration).

Function
REQ-010 A call SHALL start on a rising edge of gcd_req (req high now, registered req_d low) while the state is IDLE; a held-high gcd_req SHALL NOT start a second call.
REQ-011 gcd_a and gcd_b SHALL be captured on the start edge; changes to them while busy SHALL be ignored.
REQ-012 gcd_busy SHALL rise in the cycle after the start edge and stay high until the result is written.
REQ-013 States SHALL be IDLE, INIT, SHIFT, REDUCE and DONE; each step SHALL take one cycle.
REQ-014 In INIT, if a==0 the result SHALL be b; else if b==0 the result SHALL be a (so gcd(0,0)=0), and the state SHALL go to DONE; otherwise k=0 and the state SHALL go to SHIFT.
REQ-015 In SHIFT, if a and b are both even then a>>=1, b>>=1 and k+=1; otherwise the state SHALL go to REDUCE.
REQ-016 In REDUCE, apply the first matching rule: a==b gives result = a<<k, then DONE; a even gives a>>=1; b even gives b>>=1; a>b gives a=(a-b)>>1; otherwise b=(b-a)>>1.
REQ-017 Subtraction SHALL be unsigned at WIDTH bits; k SHALL be ceil(log2(WIDTH))+1 bits; the result shift SHALL be truncated to WIDTH bits.
REQ-018 In DONE, gcd_return SHALL load the result, gcd_busy SHALL fall in the same edge, and the state SHALL return to IDLE.
REQ-019 gcd_return SHALL hold its value until the next DONE.
REQ-020 gcd_busy SHALL be low for at least one cycle between calls.
REQ-021 Total latency from the start edge to gcd_busy low SHALL be at most 3*WIDTH+3 cycles.
REQ-022 A rising edge of gcd_req while busy SHALL be ignored and SHALL NOT be queued.

Reset
REQ-023 Reset SHALL force the state to IDLE, gcd_busy=0, gcd_return=0, gcd_err=0, req_d=0, a=b=k=0.
REQ-024 Reset asserted mid-call SHALL abort the call; no result SHALL be written.
REQ-025 After reset, a gcd_req already high SHALL count as a rising edge on the first cycle after release.

Configuration
REQ-026 The macro GCD_WATCHDOG_EN SHALL, when defined, add a step counter cleared at INIT.
REQ-027 With GCD_WATCHDOG_EN defined, if the counter reaches 4*WIDTH while in SHIFT or REDUCE, the block SHALL go to DONE with result 0 and set gcd_err=1.
REQ-028 With GCD_WATCHDOG_EN defined, gcd_err SHALL clear at the next start edge.
REQ-029 Without GCD_WATCHDOG_EN, the counter SHALL be absent and gcd_err SHALL be tied to 0.

Verification
REQ-030 Drive a=48, b=18 and pulse req -> busy high the next cycle; later busy falls with gcd_return=6.
REQ-031 Drive a=0, b=7, then a=0, b=0 -> gcd_return=7, then 0, each within 3 cycles of start.
REQ-032 Drive a=0x80000000, b=0x00100000 -> gcd_return=0x00100000; drive a=0xFFFFFFFF, b=1 -> gcd_return=1, within 99 cycles.
REQ-033 Hold req high after a=12, b=8 completes -> exactly one call, gcd_return=4, busy stays low thereafter.
REQ-034 Change a and b mid-call, and re-pulse req while busy -> result uses the captured operands and no second call occurs.
REQ-035 Assert reset mid-call -> busy=0 and gcd_return=0 immediately; the next call, a=21 and b=14, returns 7; with the macro defined, gcd_err stays 0 in every case.
